// File: rtl/udi_spect_acc_ctl.sv
// rtl/udi_spect_acc_ctl.sv - I/Q squaring sequencer: windowed power average with threshold detect
module udi_spect_acc_ctl #(
  parameter int MULT_LAT = 3,
  parameter int ACC_W    = 44,
  parameter int WIN_MAX  = 10
) (
  input  logic        gclk,
  input  logic        greset,
  input  logic        cfg_wr,
  input  logic [3:0]  cfg_win_log2,
  input  logic [31:0] cfg_thr,
  input  logic        start,
  input  logic        abort,
  input  logic        smp_valid,
  output logic        smp_ready,
  input  logic [15:0] smp_i,
  input  logic [15:0] smp_q,
  output logic [15:0] mul_a_i,
  output logic [15:0] mul_a_q,
  input  logic [31:0] mul_p_i,
  input  logic [31:0] mul_p_q,
  output logic        busy,
  output logic        res_valid,
  output logic [31:0] res_power,
  output logic        res_det
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t               state, state_nx;
  logic [3:0]           k_reg;
  logic [31:0]          thr_reg;
  logic [WIN_MAX:0]     count;
  logic [WIN_MAX:0]     win_last;
  logic [MULT_LAT:0]    tag;
  logic [ACC_W-1:0]     acc;
  logic [ACC_W-1:0]     acc_shr;
  logic [32:0]          psum;
  logic [31:0]          power_sat;
  logic [3:0]           k_clamp;
  logic                 accept;
  logic                 last_smp;
  logic                 idle_cmd;

  assign smp_ready = (state == S_RUN);
  assign busy      = (state != S_IDLE);
  assign accept    = smp_ready & smp_valid;
  assign win_last  = ((WIN_MAX+1)'(1) << k_reg) - (WIN_MAX+1)'(1);
  assign last_smp  = accept & (count == win_last);
  assign idle_cmd  = (state == S_IDLE) & ~abort;
  assign k_clamp   = (cfg_win_log2 > 4'(WIN_MAX)) ? 4'(WIN_MAX) : cfg_win_log2;
  assign psum      = {1'b0, mul_p_i} + {1'b0, mul_p_q};
  assign acc_shr   = acc >> k_reg;
  // Average cannot exceed 32 bits for legal K, but saturate rather than wrap anyway
  assign power_sat = (|acc_shr[ACC_W-1:32]) ? 32'hFFFF_FFFF : acc_shr[31:0];

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (!abort && start) state_nx = S_RUN;
      S_RUN:   if (abort) state_nx = S_IDLE;
               else if (last_smp) state_nx = S_DRAIN;
      S_DRAIN: if (abort) state_nx = S_IDLE;
               else if (tag == '0) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge gclk) begin
    if (greset) begin
      state     <= S_IDLE;
      k_reg     <= '0;
      thr_reg   <= '0;
      count     <= '0;
      tag       <= '0;
      acc       <= '0;
      mul_a_i   <= '0;
      mul_a_q   <= '0;
      res_valid <= 1'b0;
      res_power <= '0;
      res_det   <= 1'b0;
    end else begin
      state     <= state_nx;
      res_valid <= 1'b0;
      if (idle_cmd && cfg_wr) begin
        k_reg   <= k_clamp;
        thr_reg <= cfg_thr;
      end
      if (idle_cmd && start) begin
        acc   <= '0;
        count <= '0;
        tag   <= '0;
      end
      if (accept) begin
        mul_a_i <= smp_i;
        mul_a_q <= smp_q;
        count   <= count + (WIN_MAX+1)'(1);
      end
      // Tag output marks which squarer results belong to accepted samples
      if (state == S_RUN || state == S_DRAIN) begin
        if (abort) begin
          tag <= '0;
        end else begin
          tag <= {tag[MULT_LAT-1:0], accept};
          if (tag[MULT_LAT]) acc <= acc + ACC_W'(psum);
        end
      end
      if (state == S_DONE && !abort) begin
        res_power <= power_sat;
        res_det   <= (power_sat > thr_reg);
        res_valid <= 1'b1;
      end
    end
  end

endmodule
